// File: rtl/control_unit.sv
// Purpose: processor control FSM; owns PC/IR, fetches from sync ROM, drives data memory, register file and ALU controls.
// Latency: 3 cycles per NOOP/STORE/ADD/SUB instruction and 4 per LOAD; outputs are Moore (state register and IR only).
// Backpressure: none, free-running; only Reset can interrupt sequencing, and HALT parks the FSM until the next Reset.
module control_unit #(
    parameter int PC_W  = 5,
    parameter int D_AW  = 8,
    parameter int RF_AW = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       I_data,
    output logic [PC_W-1:0]   I_addr,
    output logic [15:0]       ir_instruction,
    output logic [PC_W-1:0]   pc_address,
    output logic [D_AW-1:0]   D_addr,
    output logic              D_rd,
    output logic              D_wr,
    output logic              RF_s,
    output logic [RF_AW-1:0]  RF_W_addr,
    output logic              RF_W_en,
    output logic [RF_AW-1:0]  RF_Ra_addr,
    output logic [RF_AW-1:0]  RF_Rb_addr,
    output logic [2:0]        Alu_s0,
    output logic [3:0]        state_o
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PC_W-1:0]   pc;
    logic [15:0]       ir;
    logic              fetch_ld;

    // Fields of the current instruction; LOAD/STORE reuse [11:4] as the data address.
    logic [3:0]        ir_op;
    logic [D_AW-1:0]   ir_daddr;
    logic [RF_AW-1:0]  ir_ra;
    logic [RF_AW-1:0]  ir_rb;
    logic [RF_AW-1:0]  ir_rd;

    assign ir_op    = ir[15:12];
    assign ir_daddr = ir[4 +: D_AW];
    assign ir_ra    = ir[8 +: RF_AW];
    assign ir_rb    = ir[4 +: RF_AW];
    assign ir_rd    = ir[0 +: RF_AW];

    assign I_addr         = pc;
    assign pc_address     = pc;
    assign ir_instruction = ir;
    assign state_o        = state;

    // State register plus PC/IR; IR captures ROM data and PC steps only on leaving FETCH.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_INIT;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (fetch_ld) begin
                ir <= I_data;
                pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state selection and Moore output decode; anything not driven in a state stays 0.
    always_comb begin
        state_nxt  = S_INIT;
        fetch_ld   = 1'b0;
        D_addr     = '0;
        D_rd       = 1'b0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        Alu_s0     = 3'd0;
        case (state)
            S_INIT: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                // PC has been stable for at least one cycle, so I_data is ROM[PC].
                fetch_ld  = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (ir_op)
                    4'd1:    state_nxt = S_STORE;
                    4'd2:    state_nxt = S_LOAD_A;
                    4'd3:    state_nxt = S_ADD;
                    4'd4:    state_nxt = S_SUB;
                    4'd5:    state_nxt = S_HALT;
                    default: state_nxt = S_NOOP;
                endcase
            end
            S_NOOP: begin
                state_nxt = S_FETCH;
            end
            S_LOAD_A: begin
                D_addr    = ir_daddr;
                D_rd      = 1'b1;
                state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                D_addr    = ir_daddr;
                RF_s      = 1'b1;
                RF_W_addr = ir_rd;
                RF_W_en   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_STORE: begin
                D_addr     = ir_daddr;
                RF_Ra_addr = ir_rd;
                D_wr       = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_ADD: begin
                RF_Ra_addr = ir_ra;
                RF_Rb_addr = ir_rb;
                RF_W_addr  = ir_rd;
                RF_W_en    = 1'b1;
                Alu_s0     = 3'd1;
                state_nxt  = S_FETCH;
            end
            S_SUB: begin
                RF_Ra_addr = ir_ra;
                RF_Rb_addr = ir_rb;
                RF_W_addr  = ir_rd;
                RF_W_en    = 1'b1;
                Alu_s0     = 3'd2;
                state_nxt  = S_FETCH;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                // Unused codes 10-15 fall back to INIT on the next edge.
                state_nxt = S_INIT;
            end
        endcase
    end

endmodule
